// File: rtl/prescaler_lib.sv
// Shared definitions for the programmable prescaler.
// Provides the default divisor width/value, the divisor type and a helper
// that sizes the channel-select field of the configuration port.
package prescaler_lib;

  localparam int unsigned DIV_WIDTH   = 16;
  localparam int unsigned DEFAULT_DIV = 9;

  typedef bit [DIV_WIDTH-1:0] Div_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned ch_idx_w(input int unsigned ch_num);
    return (ch_num > 1) ? $clog2(ch_num) : 1;
  endfunction

endpackage

// File: rtl/prescaler_div_ch.sv
// One prescaler channel: down-counter with reload, shadow divisor and
// registered tick / square outputs.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   i_act       count enable for this cycle (already cascade-qualified)
//   i_clr       synchronous restart of the current period
//   i_wr        accepted configuration write strobe
//   i_wdata     new divisor for the shadow register
//   o_pend      shadow divisor waiting for the next period boundary
//   o_tick      one-cycle pulse at the end of each period
//   o_sq        toggles on every tick
module prescaler_div_ch #(
  parameter int unsigned DIV_WIDTH   = prescaler_lib::DIV_WIDTH,
  parameter int unsigned DEFAULT_DIV = prescaler_lib::DEFAULT_DIV
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_act,
  input  logic                 i_clr,
  input  logic                 i_wr,
  input  logic [DIV_WIDTH-1:0] i_wdata,
  output logic                 o_pend,
  output logic                 o_tick,
  output logic                 o_sq
);

  localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(DEFAULT_DIV);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_reload;
  logic [DIV_WIDTH-1:0] r_shadow;
  logic                 r_pend;
  logic                 r_tick;
  logic                 r_sq;

  logic [DIV_WIDTH-1:0] w_cnt_nxt;
  logic [DIV_WIDTH-1:0] w_reload_nxt;
  logic [DIV_WIDTH-1:0] w_shadow_nxt;
  logic                 w_pend_nxt;
  logic                 w_tick_nxt;
  logic                 w_sq_nxt;
  logic [DIV_WIDTH-1:0] w_apply;

  // Divisor for the next period: a pending shadow wins over the old reload.
  assign w_apply = r_pend ? r_shadow : r_reload;

  // Next-state: clr > terminal > decrement > hold, then config write.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_reload_nxt = r_reload;
    w_shadow_nxt = r_shadow;
    w_pend_nxt   = r_pend;
    w_tick_nxt   = 1'b0;
    w_sq_nxt     = r_sq;

    if (i_clr) begin
      w_cnt_nxt    = w_apply;
      w_reload_nxt = w_apply;
      w_pend_nxt   = 1'b0;
    end else if (i_act) begin
      if (r_cnt == '0) begin
        w_tick_nxt   = 1'b1;
        w_sq_nxt     = ~r_sq;
        w_cnt_nxt    = w_apply;
        w_reload_nxt = w_apply;
        w_pend_nxt   = 1'b0;
      end else begin
        w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
      end
    end

    // Strobe is only raised while pend is clear, so it never races an apply.
    if (i_wr) begin
      w_shadow_nxt = i_wdata;
      w_pend_nxt   = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= RST_DIV;
      r_reload <= RST_DIV;
      r_shadow <= RST_DIV;
      r_pend   <= 1'b0;
      r_tick   <= 1'b0;
      r_sq     <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_reload <= w_reload_nxt;
      r_shadow <= w_shadow_nxt;
      r_pend   <= w_pend_nxt;
      r_tick   <= w_tick_nxt;
      r_sq     <= w_sq_nxt;
    end
  end

  assign o_pend = r_pend;
  assign o_tick = r_tick;
  assign o_sq   = r_sq;

endmodule

// File: rtl/prescaler_div.sv
// Multi-channel programmable clock-enable prescaler.
// Each channel divides clk by (div+1), producing a registered tick and a
// square wave. Divisor writes go through a valid/ready port into a shadow
// register that is applied at the next period boundary or clr.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   en          per-channel count enable
//   clr         per-channel synchronous restart
//   cfg_valid   config write request
//   cfg_ready   write accepted when high with cfg_valid (combinational)
//   cfg_ch      target channel; out-of-range writes are dropped
//   cfg_div     new divisor
//   pend        per-channel shadow-pending flags
//   tick        per-channel one-cycle period pulse
//   sq          per-channel square output
module prescaler_div #(
  parameter int unsigned CH_NUM      = 4,
  parameter int unsigned DIV_WIDTH   = prescaler_lib::DIV_WIDTH,
  parameter int unsigned DEFAULT_DIV = prescaler_lib::DEFAULT_DIV,
  parameter int unsigned CASCADE     = 0
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [CH_NUM-1:0]                          en,
  input  logic [CH_NUM-1:0]                          clr,
  input  logic                                       cfg_valid,
  output logic                                       cfg_ready,
  input  logic [prescaler_lib::ch_idx_w(CH_NUM)-1:0] cfg_ch,
  input  logic [DIV_WIDTH-1:0]                       cfg_div,
  output logic [CH_NUM-1:0]                          pend,
  output logic [CH_NUM-1:0]                          tick,
  output logic [CH_NUM-1:0]                          sq
);

  localparam int unsigned CH_W = prescaler_lib::ch_idx_w(CH_NUM);

  logic              w_ready;
  logic [CH_NUM-1:0] w_wr;
  logic [CH_NUM-1:0] w_act;

  // Ready mirrors the addressed channel's free shadow; unknown channels
  // stay ready so a stray write is swallowed instead of stalling.
  always_comb begin
    w_ready = 1'b1;
    for (int i = 0; i < int'(CH_NUM); i++) begin
      if (cfg_ch == CH_W'(i)) begin
        w_ready = ~pend[i];
      end
    end
  end

  assign cfg_ready = w_ready;

  for (genvar i = 0; i < int'(CH_NUM); i++) begin : g_ch
    assign w_wr[i] = cfg_valid & w_ready & (cfg_ch == CH_W'(i));

    // Cascaded stages advance on the previous stage's registered tick.
    if ((CASCADE != 0) && (i > 0)) begin : g_casc
      assign w_act[i] = en[i] & tick[i-1];
    end else begin : g_ind
      assign w_act[i] = en[i];
    end

    prescaler_div_ch #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_act   (w_act[i]),
      .i_clr   (clr[i]),
      .i_wr    (w_wr[i]),
      .i_wdata (cfg_div),
      .o_pend  (pend[i]),
      .o_tick  (tick[i]),
      .o_sq    (sq[i])
    );
  end

endmodule

// File: tb/tb_prescaler_div.sv
// Bench for prescaler_div: an independent 4-channel instance and a
// cascaded 3-channel instance share stimulus and are compared every cycle
// against a count-up period model, plus hand-computed directed checks.
module tb_prescaler_div;

  logic        clk;
  logic        rst_n;
  logic [3:0]  en;
  logic [3:0]  clr;
  logic        cfg_valid;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        rdy0, rdy1;
  logic [3:0]  pend0, tick0, sq0;
  logic [2:0]  pend1, tick1, sq1;

  int n_checks = 0;
  int n_fail   = 0;

  prescaler_div #(.CH_NUM(4), .DIV_WIDTH(16), .DEFAULT_DIV(9), .CASCADE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .cfg_valid(cfg_valid), .cfg_ready(rdy0), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .pend(pend0), .tick(tick0), .sq(sq0)
  );

  prescaler_div #(.CH_NUM(3), .DIV_WIDTH(16), .DEFAULT_DIV(9), .CASCADE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en[2:0]), .clr(clr[2:0]),
    .cfg_valid(cfg_valid), .cfg_ready(rdy1), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .pend(pend1), .tick(tick1), .sq(sq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: position within the current period counts up to the period's
  // divisor; a new divisor only takes over when a period starts.
  int nch [2] = '{4, 3};
  int m_pos [2][4];
  int m_div [2][4];
  int m_shd [2][4];
  bit m_pend[2][4];
  bit m_tick[2][4];
  bit m_sq  [2][4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        m_pos[d][c] = 0;  m_div[d][c] = 9;  m_shd[d][c] = 9;
        m_pend[d][c] = 0; m_tick[d][c] = 0; m_sq[d][c] = 0;
      end
    end
  endtask

  function automatic bit exp_ready(input int d);
    if (int'(cfg_ch) >= nch[d]) return 1'b1;
    return !m_pend[d][cfg_ch];
  endfunction

  task automatic model_step();
    bit pt[2][4];
    pt = m_tick;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < nch[d]; c++) begin
        bit act;
        bit wr;
        act = en[c];
        if (d == 1 && c > 0) act = act && pt[d][c-1];
        wr = cfg_valid && (int'(cfg_ch) == c) && !m_pend[d][c];
        if (clr[c]) begin
          if (m_pend[d][c]) m_div[d][c] = m_shd[d][c];
          m_pend[d][c] = 0;
          m_pos[d][c]  = 0;
          m_tick[d][c] = 0;
        end else if (act && m_pos[d][c] == m_div[d][c]) begin
          m_tick[d][c] = 1;
          m_sq[d][c]   = !m_sq[d][c];
          if (m_pend[d][c]) begin
            m_div[d][c]  = m_shd[d][c];
            m_pend[d][c] = 0;
          end
          m_pos[d][c] = 0;
        end else begin
          if (act) m_pos[d][c]++;
          m_tick[d][c] = 0;
        end
        if (wr) begin
          m_shd[d][c]  = int'(cfg_div);
          m_pend[d][c] = 1;
        end
      end
    end
  endtask

  // One clock: ready check on settled inputs, model at the edge, outputs
  // compared on the falling edge. Called right after a falling edge.
  task automatic cyc();
    logic [3:0] et, es, ep;
    #1;
    chk("cfg_ready0", 32'(rdy0), 32'(exp_ready(0)));
    chk("cfg_ready1", 32'(rdy1), 32'(exp_ready(1)));
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      et = '0; es = '0; ep = '0;
      for (int c = 0; c < nch[d]; c++) begin
        et[c] = m_tick[d][c];
        es[c] = m_sq[d][c];
        ep[c] = m_pend[d][c];
      end
      if (d == 0) begin
        chk("tick0", 32'(tick0), 32'(et));
        chk("sq0",   32'(sq0),   32'(es));
        chk("pend0", 32'(pend0), 32'(ep));
      end else begin
        chk("tick1", 32'({1'b0, tick1}), 32'(et));
        chk("sq1",   32'({1'b0, sq1}),   32'(es));
        chk("pend1", 32'({1'b0, pend1}), 32'(ep));
      end
    end
  endtask

  initial begin
    bit prev_sq;
    rst_n = 1'b0; en = '0; clr = '0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tick", 32'(tick0), 32'h0);
    chk("rst_sq",   32'(sq0),   32'h0);
    chk("rst_pend", 32'(pend0), 32'h0);
    chk("rst_rdy",  32'(rdy0),  32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Default period, mid-period rewrite, blocked rewrite, clr on terminal.
    en = 4'b0001;
    for (int k = 1; k <= 40; k++) begin
      cfg_valid = (k == 15 || k == 16 || k == 17);
      cfg_ch    = (k == 17) ? 2'd1 : 2'd0;
      cfg_div   = (k == 15) ? 16'd3 : ((k == 16) ? 16'd7 : 16'd5);
      clr       = (k == 32) ? 4'b0001 : 4'b0000;
      if (k == 16) begin
        #1;
        chk("ready_blocked", 32'(rdy0), 32'h0);
      end
      cyc();
      chk("dir_tick", 32'(tick0[0]),
          32'(k == 10 || k == 20 || k == 24 || k == 28 || k == 36 || k == 40));
      if (k == 15) chk("pend_set", 32'(pend0[0]), 32'h1);
      if (k == 17) chk("pend_ch1", 32'(pend0[1]), 32'h1);
      if (k == 20) chk("pend_clr", 32'(pend0[0]), 32'h0);
      if (k == 19) chk("sq_hi",    32'(sq0[0]),   32'h1);
      if (k == 32) chk("sq_clr",   32'(sq0[0]),   32'h0);
    end
    cfg_valid = 1'b0; clr = '0;

    // Cascade: ch0 div=1, ch1 div=2 on the cascaded instance.
    en = 4'h0; clr = 4'hF; cyc();
    clr = 4'h0; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd1; cyc();
    cfg_ch = 2'd1; cfg_div = 16'd2; cyc();
    cfg_valid = 1'b0; clr = 4'hF; cyc();
    clr = 4'h0; en = 4'hF;
    for (int j = 1; j <= 30; j++) begin
      cyc();
      chk("casc_t0", 32'(tick1[0]), 32'(j % 2 == 0));
      chk("casc_t1", 32'(tick1[1]), 32'(j >= 7 && (j - 7) % 6 == 0));
    end

    // Divisor 0 on ch2, parked write on ch3, then async reset mid-run.
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd0; cyc();
    cfg_ch = 2'd3; cfg_div = 16'd4; en = 4'b0111; cyc();
    cfg_valid = 1'b0; clr = 4'b0100; cyc();
    clr = 4'h0;
    prev_sq = sq0[2];
    for (int j = 1; j <= 8; j++) begin
      cyc();
      chk("d0_tick", 32'(tick0[2]), 32'h1);
      chk("d0_sq",   32'(sq0[2]),   32'(!prev_sq));
      prev_sq = sq0[2];
    end
    chk("park_pend", 32'(pend0[3]), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tick0", 32'(tick0), 32'h0);
    chk("arst_sq0",   32'(sq0),   32'h0);
    chk("arst_pend0", 32'(pend0), 32'h0);
    chk("arst_tick1", 32'(tick1), 32'h0);
    chk("arst_sq1",   32'(sq1),   32'h0);
    chk("arst_pend1", 32'(pend1), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; en = 4'b0001;
    for (int j = 1; j <= 10; j++) begin
      cyc();
      chk("post_rst_tick", 32'(tick0[0]), 32'(j == 10));
    end

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      en        = 4'($urandom() | $urandom());
      clr       = ($urandom_range(0, 31) == 0) ? 4'($urandom()) : 4'h0;
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = 2'($urandom());
      cfg_div   = 16'($urandom_range(0, 6));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
